lsu_mem_master: RTL and testbench

- Initiator side of the data-memory interface: accepts one load/store request at a time from the core pipeline over a valid/ready handshake.
- Drives a word-organised, synchronous-read memory port with word-aligned addresses, lane-shifted write data and byte masks.
- Splits accesses that straddle a word boundary into two word transactions.
- Returns sign- or zero-extended load data over a valid/ready response channel.

---
 rtl/lsu_mem_master.sv | 273 +++++++++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store unit memory master.
// Takes one load/store request at a time and drives a word-organised memory
// with a synchronous read. An access that crosses a word boundary becomes
// two word transactions. Load data comes back sign- or zero-extended.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   reqValid/reqReady              request handshake (reqReady high only in IDLE)
//   reqAddr/reqWdata/reqOp/reqWe   byte address, right-aligned store data, op, store flag
//   respValid/respReady            response handshake
//   respData/respErr               extended load data, error flag
//   memAddr/memWdata/memWmask      word address, lane-shifted write data, byte enables
//   memWe/memRe/memRdata           write strobe, read strobe, read data (one cycle after memRe)
module lsu_mem_master #(
  parameter int unsigned addrWidth       = 32,
  parameter bit          allowMisaligned = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic [addrWidth-1:0] reqAddr,
  input  logic [31:0]          reqWdata,
  input  logic [2:0]           reqOp,
  input  logic                 reqWe,
  output logic                 respValid,
  input  logic                 respReady,
  output logic [31:0]          respData,
  output logic                 respErr,
  output logic [addrWidth-1:0] memAddr,
  output logic [31:0]          memWdata,
  output logic [3:0]           memWmask,
  output logic                 memWe,
  output logic                 memRe,
  input  logic [31:0]          memRdata
);

  localparam int unsigned DataWidth = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE0  = 3'd1,
    S_ISSUE1  = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Latched request and first read word
  logic [addrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [2:0]           op_q, op_d;
  logic                 we_q, we_d;
  logic [DataWidth-1:0] lo_q, lo_d;

  // Output registers
  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [DataWidth-1:0] resp_data_q, resp_data_d;
  logic                 resp_err_q, resp_err_d;
  logic [addrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]           mem_wmask_q, mem_wmask_d;
  logic                 mem_we_q, mem_we_d;
  logic                 mem_re_q, mem_re_d;

  logic accept;
  assign accept = reqValid && (state_q == S_IDLE);

  // Capture the request on accept, otherwise hold
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    we_d    = we_q;
    if (accept) begin
      addr_d  = reqAddr;
      wdata_d = reqWdata;
      op_d    = reqOp;
      we_d    = reqWe;
    end
  end

  // Lane math, evaluated on the request as it will be held next cycle
  logic [1:0]           off;
  logic [3:0]           size_mask;
  logic [7:0]           mask8;
  logic [63:0]          wide;
  logic                 split;
  logic [addrWidth-1:0] word_a;
  logic [addrWidth-1:0] word_b;
  logic                 op_legal;
  logic                 misaligned;
  logic                 illegal;

  assign off    = addr_d[1:0];
  assign mask8  = {4'b0000, size_mask} << off;
  assign wide   = {32'h0, wdata_d} << {off, 3'b000};
  assign split  = |mask8[7:4];
  assign word_a = {addr_d[addrWidth-1:2], 2'b00};
  assign word_b = word_a + addrWidth'(4);

  always_comb begin
    case (op_d[1:0])
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  always_comb begin
    case (op_d)
      3'd0, 3'd1, 3'd2: op_legal = 1'b1;
      3'd4, 3'd5:       op_legal = !we_d;
      default:          op_legal = 1'b0;
    endcase
  end

  assign misaligned = ((op_d[1:0] == 2'd1) && off[0]) ||
                      ((op_d[1:0] == 2'd2) && (off != 2'd0));
  assign illegal    = !op_legal || (!allowMisaligned && misaligned);

  // Load data assembly: the high word is the current read only for split loads
  logic [63:0]          rd_pair;
  logic [63:0]          rd_pair_sh;
  logic [DataWidth-1:0] rd_shift;
  logic [DataWidth-1:0] load_data;

  assign rd_pair    = split ? {memRdata, lo_q} : {32'h0, memRdata};
  assign rd_pair_sh = rd_pair >> {off, 3'b000};
  assign rd_shift   = rd_pair_sh[31:0];

  always_comb begin
    case (op_q)
      3'd0:    load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd1:    load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'd4:    load_data = {24'h0, rd_shift[7:0]};
      3'd5:    load_data = {16'h0, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  assign lo_d = (state_q == S_ISSUE1) ? memRdata : lo_q;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = illegal ? S_RESP : S_ISSUE0;
        end
      end
      S_ISSUE0: begin
        if (split) begin
          state_d = S_ISSUE1;
        end else begin
          state_d = we_q ? S_RESP : S_CAPTURE;
        end
      end
      S_ISSUE1:  state_d = we_q ? S_RESP : S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP: begin
        if (respReady) begin
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic: values for the state being entered, registered below
  always_comb begin
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    mem_wmask_d  = 4'b0000;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    case (state_d)
      S_ISSUE0: begin
        mem_addr_d = word_a;
        if (we_d) begin
          mem_we_d    = 1'b1;
          mem_wmask_d = mask8[3:0];
          mem_wdata_d = wide[31:0];
        end else begin
          mem_re_d = 1'b1;
        end
      end
      S_ISSUE1: begin
        mem_addr_d = word_b;
        if (we_d) begin
          mem_we_d    = 1'b1;
          mem_wmask_d = mask8[7:4];
          mem_wdata_d = wide[63:32];
        end else begin
          mem_re_d = 1'b1;
        end
      end
      S_RESP: begin
        resp_valid_d = 1'b1;
        if (state_q == S_RESP) begin
          resp_data_d = resp_data_q;
          resp_err_d  = resp_err_q;
        end else if (state_q == S_CAPTURE) begin
          resp_data_d = load_data;
        end else if (state_q == S_IDLE) begin
          resp_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      op_q         <= 3'd0;
      we_q         <= 1'b0;
      lo_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= 4'b0000;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_q         <= op_d;
      we_q         <= we_d;
      lo_q         <= lo_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
    end
  end

  assign reqReady  = req_ready_q;
  assign respValid = resp_valid_q;
  assign respData  = resp_data_q;
  assign respErr   = resp_err_q;
  assign memAddr   = mem_addr_q;
  assign memWdata  = mem_wdata_q;
  assign memWmask  = mem_wmask_q;
  assign memWe     = mem_we_q;
  assign memRe     = mem_re_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master: byte-level reference model, word memory
// model, scoreboard queues for responses and memory strobes.
module tb_lsu_mem_master;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] data;
  } strobe_t;

  logic        clk;
  logic        rstn;
  logic        reqValid, reqReady, reqWe;
  logic [31:0] reqAddr, reqWdata;
  logic [2:0]  reqOp;
  logic        respValid, respReady, respErr;
  logic [31:0] respData;
  logic [31:0] memAddr, memWdata, memRdata;
  logic [3:0]  memWmask;
  logic        memWe, memRe;

  logic        na_req_valid, na_req_ready, na_req_we;
  logic [31:0] na_req_addr, na_req_wdata;
  logic [2:0]  na_req_op;
  logic        na_resp_valid, na_resp_ready, na_resp_err;
  logic [31:0] na_resp_data, na_mem_addr, na_mem_wdata;
  logic [3:0]  na_mem_wmask;
  logic        na_mem_we, na_mem_re;

  lsu_mem_master #(.addrWidth(32), .allowMisaligned(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr),
    .reqWdata(reqWdata), .reqOp(reqOp), .reqWe(reqWe),
    .respValid(respValid), .respReady(respReady), .respData(respData), .respErr(respErr),
    .memAddr(memAddr), .memWdata(memWdata), .memWmask(memWmask),
    .memWe(memWe), .memRe(memRe), .memRdata(memRdata)
  );

  lsu_mem_master #(.addrWidth(32), .allowMisaligned(1'b0)) dut_na (
    .clk(clk), .rstn(rstn),
    .reqValid(na_req_valid), .reqReady(na_req_ready), .reqAddr(na_req_addr),
    .reqWdata(na_req_wdata), .reqOp(na_req_op), .reqWe(na_req_we),
    .respValid(na_resp_valid), .respReady(na_resp_ready), .respData(na_resp_data), .respErr(na_resp_err),
    .memAddr(na_mem_addr), .memWdata(na_mem_wdata), .memWmask(na_mem_wmask),
    .memWe(na_mem_we), .memRe(na_mem_re), .memRdata(32'h0)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  int stall_req  = 0;
  int stall_done = 0;

  exp_t    exp_q[$];
  strobe_t stb_q[$];

  logic [31:0] mem_words [logic [31:0]];
  logic [7:0]  ref_mem   [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return {wa[15:0], ~wa[15:0]} ^ 32'hA5C3_0F96;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (mem_words.exists(wa)) return mem_words[wa];
    return init_word(wa);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  // Word memory with synchronous read and byte-masked write
  initial begin
    memRdata = 32'h0;
    forever begin
      @(posedge clk);
      if (memRe) memRdata <= mem_rd(memAddr);
      if (memWe) begin
        mem_words[memAddr] = (mem_rd(memAddr) & ~lane_mask(memWmask)) |
                             (memWdata & lane_mask(memWmask));
      end
    end
  end

  // Reference model: one request in terms of bytes touched
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op,
                       input logic we, output exp_t e);
    int size, nwords;
    bit legal;
    logic [31:0] v, b, wa;
    strobe_t s;
    size  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    legal = (op == 3'd0 || op == 3'd1 || op == 3'd2) || (!we && (op == 3'd4 || op == 3'd5));
    e.data = 32'h0;
    e.err  = 1'b0;
    if (!legal) begin
      e.err = 1'b1;
      e.lat = 1;
      return;
    end
    nwords = (int'(a[1:0]) + size > 4) ? 2 : 1;
    for (int w = 0; w < nwords; w++) begin
      wa = {a[31:2], 2'b00} + 32'(4 * w);
      s.addr = wa; s.we = we; s.mask = 4'b0000; s.data = 32'h0;
      for (int i = 0; i < size; i++) begin
        b = a + 32'(i);
        if ({b[31:2], 2'b00} == wa) begin
          s.mask[b[1:0]] = 1'b1;
          s.data[8*b[1:0] +: 8] = d[8*i +: 8];
        end
      end
      stb_q.push_back(s);
    end
    if (we) begin
      for (int i = 0; i < size; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
      e.lat = 1 + nwords;
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_byte(a + 32'(i));
      if (!op[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
      if (!op[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      e.data = v;
      e.lat  = 2 + nwords;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op,
                      input logic we, input bit use_exp, input logic [31:0] exp_val);
    exp_t e;
    int n;
    @(negedge clk);
    reqAddr = a; reqWdata = d; reqOp = op; reqWe = we; reqValid = 1'b1;
    n = 0;
    while (!reqReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!reqReady) begin
      chk("req_accept_timeout", 32'd1, 32'd0);
      reqValid = 1'b0;
      return;
    end
    model(a, d, op, we, e);
    if (use_exp) e.data = exp_val;
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    reqAddr  = $urandom; reqWdata = $urandom; reqOp = 3'($urandom); reqWe = 1'($urandom);
  endtask

  // Monitor: strobes, response handshake, stability under backpressure
  initial begin
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_err;
    int          first_cyc;
    exp_t        e;
    strobe_t     s;
    prev_stall = 1'b0; prev_data = 32'h0; prev_err = 1'b0; first_cyc = 0;
    respReady = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        respReady  = 1'b1;
        prev_stall = 1'b0;
      end else begin
        if (memRe || memWe) begin
          chk("no_dual_strobe", 32'(memRe & memWe), 32'd0);
          if (stb_q.size() == 0) begin
            chk("unexpected_strobe", 32'd1, 32'd0);
          end else begin
            s = stb_q.pop_front();
            chk("strobe_addr", memAddr, s.addr);
            chk("strobe_kind_we", 32'(memWe), 32'(s.we));
            if (s.we) begin
              chk("strobe_wmask", 32'(memWmask), 32'(s.mask));
              chk("strobe_wdata", memWdata & lane_mask(s.mask), s.data);
            end
          end
        end
        if (prev_stall) begin
          chk("stall_valid_held", 32'(respValid), 32'd1);
          chk("stall_data_held", respData, prev_data);
          chk("stall_err_held", 32'(respErr), 32'(prev_err));
        end
        if (respValid) begin
          chk("req_ready_low_in_resp", 32'(reqReady), 32'd0);
          if (!prev_stall) first_cyc = cyc;
          if (stall_done < stall_req) begin
            respReady = 1'b0;
            stall_done++;
          end else begin
            respReady = ($urandom_range(0, 9) < 7);
          end
          if (respReady) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_response", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("resp_data", respData, e.data);
              chk("resp_err", 32'(respErr), 32'(e.err));
              chk("latency", 32'(first_cyc - e.acc_cyc), 32'(e.lat));
              chk("strobes_consumed", 32'(stb_q.size()), 32'd0);
            end
          end
          prev_stall = !respReady;
          prev_data  = respData;
          prev_err   = respErr;
        end else begin
          respReady  = 1'(($urandom_range(0, 1)));
          prev_stall = 1'b0;
        end
      end
    end
  end

  // Main stimulus
  initial begin
    logic [31:0] base, a;
    logic [2:0]  op;
    logic        we;
    int          n, we_cnt;
    logic [2:0]  legal_ops [8];
    legal_ops[0] = 3'd0; legal_ops[1] = 3'd1; legal_ops[2] = 3'd2; legal_ops[3] = 3'd4;
    legal_ops[4] = 3'd5; legal_ops[5] = 3'd2; legal_ops[6] = 3'd1; legal_ops[7] = 3'd0;

    rstn = 1'b0;
    reqValid = 1'b0; reqAddr = 32'h0; reqWdata = 32'h0; reqOp = 3'd0; reqWe = 1'b0;
    na_req_valid = 1'b0; na_req_addr = 32'h0; na_req_wdata = 32'h0;
    na_req_op = 3'd0; na_req_we = 1'b0; na_resp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(reqReady), 32'd1);
    chk("rst_resp_valid", 32'(respValid), 32'd0);
    chk("rst_resp_data", respData, 32'd0);
    chk("rst_resp_err", 32'(respErr), 32'd0);
    chk("rst_mem_we", 32'(memWe), 32'd0);
    chk("rst_mem_re", 32'(memRe), 32'd0);
    chk("rst_mem_addr", memAddr, 32'd0);
    chk("rst_mem_wmask", 32'(memWmask), 32'd0);
    rstn = 1'b1;
    mon_en = 1'b1;

    // Directed cases from known memory contents
    send(32'h0000_0100, 32'hDEAD_BEEF, 3'd2, 1'b1, 1'b0, 32'h0);
    send(32'h0000_0100, 32'h0, 3'd2, 1'b0, 1'b1, 32'hDEAD_BEEF);
    send(32'h0000_0100, 32'h80FF_7F01, 3'd2, 1'b1, 1'b0, 32'h0);
    send(32'h0000_0102, 32'h0, 3'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    send(32'h0000_0103, 32'h0, 3'd4, 1'b0, 1'b1, 32'h0000_0080);
    send(32'h0000_0100, 32'h0, 3'd1, 1'b0, 1'b1, 32'h0000_7F01);
    send(32'h0000_0100, 32'h4433_2211, 3'd2, 1'b1, 1'b0, 32'h0);
    send(32'h0000_0104, 32'h8877_6655, 3'd2, 1'b1, 1'b0, 32'h0);
    send(32'h0000_0103, 32'h0, 3'd2, 1'b0, 1'b1, 32'h7766_5544);
    send(32'hFFFF_FFFF, 32'h0000_BBAA, 3'd1, 1'b1, 1'b0, 32'h0);
    send(32'hFFFF_FFFF, 32'h0, 3'd5, 1'b0, 1'b1, 32'h0000_BBAA);
    stall_req = stall_req + 5;
    send(32'h0000_0104, 32'h0, 3'd2, 1'b0, 1'b1, 32'h8877_6655);
    send(32'h0000_0200, 32'h0, 3'd3, 1'b0, 1'b1, 32'h0);
    send(32'h0000_0200, 32'h1234_5678, 3'd4, 1'b1, 1'b1, 32'h0);

    // Misaligned-illegal variant: error with no strobes, then a legal load
    @(negedge clk);
    na_req_addr = 32'h2; na_req_op = 3'd2; na_req_we = 1'b0; na_req_valid = 1'b1;
    @(posedge clk);
    #1 na_req_valid = 1'b0;
    @(negedge clk);
    chk("na_misaligned_valid", 32'(na_resp_valid), 32'd1);
    chk("na_misaligned_err", 32'(na_resp_err), 32'd1);
    chk("na_misaligned_no_re", 32'(na_mem_re), 32'd0);
    repeat (2) @(negedge clk);
    na_req_addr = 32'h4; na_req_valid = 1'b1;
    @(posedge clk);
    #1 na_req_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!na_resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("na_aligned_latency", 32'(n), 32'd3);
    chk("na_aligned_err", 32'(na_resp_err), 32'd0);

    // Randomized traffic clustered so that accesses overlap and wrap
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 2))
        0:       base = 32'h0000_0100;
        1:       base = 32'hFFFF_FFF4;
        default: base = 32'h0000_2000;
      endcase
      a  = base + 32'($urandom_range(0, 11));
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 7)];
      else op = 3'($urandom_range(0, 7));
      send(a, $urandom, op, we, 1'b0, 32'h0);
    end

    n = 0;
    while ((exp_q.size() != 0 || !reqReady) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    // Reset during the first half of a split store
    mon_en = 1'b0;
    @(negedge clk);
    reqAddr = 32'hFFFF_FFFF; reqWdata = 32'h0000_BBAA; reqOp = 3'd1; reqWe = 1'b1; reqValid = 1'b1;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    chk("rst_test_issue0_we", 32'(memWe), 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("rst_test_we_drop", 32'(memWe), 32'd0);
    chk("rst_test_re_drop", 32'(memRe), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_test_req_ready", 32'(reqReady), 32'd1);
    we_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (memWe) we_cnt++;
    end
    chk("rst_test_no_second_write", 32'(we_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
